ring_tuning_controller: RTL and testbench

- Multi-channel thermal tuner for resonant-ring modulators and receiver rings in the electro-optical cell.
- Finds each ring's resonance by sweeping a per-channel heater code and taking drop-port power samples from one shared monitor. Then keeps each ring on resonance with a round-robin dither-and-track loop.
- Drives each heater with a first-order pulse-density-modulated (PDM) bit.
- Successor to the single-channel, open-loop thermal tuner. It adds channel count, closed-loop lock and tracking.

---
 rtl/ring_tuning_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_ring_tuning_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_tuning_controller.sv
// Multi-channel ring-resonator thermal tuner: per-channel sweep to find peak drop
// power, then round-robin dither-and-track, with a first-order PDM heater drive per channel.

module ring_pdm_lane #(
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  output logic              pdm
);
  logic [CODE_W:0] acc;

  // acc[CODE_W] is the carry from the previous add, so it is already registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= {1'b0, acc[CODE_W-1:0]} + {1'b0, code};
  end

  assign pdm = acc[CODE_W];
endmodule

module ring_tuning_controller #(
  parameter int NUM_CH     = 4,
  parameter int CODE_W     = 8,
  parameter int MON_W      = 10,
  parameter int SETTLE_CYC = 16,
  parameter int STEP       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     mon_req,
  output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] mon_sel,
  input  logic                     mon_valid,
  input  logic [MON_W-1:0]         mon_power,
  output logic [NUM_CH*CODE_W-1:0] heater_code,
  output logic [NUM_CH-1:0]        heater_out,
  output logic [NUM_CH-1:0]        locked,
  output logic                     busy
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [CODE_W:0]   STEP_V   = (CODE_W+1)'(STEP);
  localparam logic [7:0]        SETTLE_V = 8'(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE, SWEEP_SET, SWEEP_WAIT, SWEEP_SAMP, TRK_SET, TRK_WAIT, TRK_SAMP
  } state_t;

  state_t                          state, state_n;
  logic [SEL_W-1:0]                ch, ch_n;
  logic [CODE_W-1:0]               c, c_n, best_code, best_code_n, orig, orig_n;
  logic [MON_W-1:0]                best, best_n;
  logic [7:0]                      cnt, cnt_n;
  logic [NUM_CH-1:0][CODE_W-1:0]   code, code_n;
  logic [NUM_CH-1:0][MON_W-1:0]    ref_pwr, ref_pwr_n;
  logic [NUM_CH-1:0]               dir, dir_n, locked_n;
  logic                            mon_req_n, req_armed, req_armed_n;
  logic [SEL_W-1:0]                mon_sel_n;

  // trial-code datapath for the current channel
  logic [CODE_W-1:0] cur, trial_up, trial_dn, trial;
  logic [CODE_W:0]   up_sum;
  logic              dir_eff;

  always_comb begin
    cur      = code[ch];
    up_sum   = {1'b0, cur} + STEP_V;
    trial_up = up_sum[CODE_W] ? CODE_MAX : up_sum[CODE_W-1:0];
    trial_dn = ({1'b0, cur} < STEP_V) ? '0 : cur - STEP_V[CODE_W-1:0];
    dir_eff  = dir[ch];
    // A saturated step would leave the code unchanged: turn around instead.
    if ((dir[ch] ? trial_dn : trial_up) == cur) dir_eff = ~dir[ch];
    trial    = dir_eff ? trial_dn : trial_up;
  end

  always_comb begin
    state_n     = state;
    ch_n        = ch;
    c_n         = c;
    best_n      = best;
    best_code_n = best_code;
    orig_n      = orig;
    cnt_n       = cnt;
    code_n      = code;
    ref_pwr_n   = ref_pwr;
    dir_n       = dir;
    locked_n    = locked;
    mon_req_n   = mon_req;
    mon_sel_n   = mon_sel;
    req_armed_n = req_armed;

    if (state != IDLE && !enable) begin
      state_n     = IDLE;
      mon_req_n   = 1'b0;
      req_armed_n = 1'b0;
      locked_n    = '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state_n     = SWEEP_SET;
          ch_n        = '0;
          c_n         = '0;
          best_n      = '0;
          best_code_n = '0;
        end
        SWEEP_SET: begin
          code_n[ch] = c;
          cnt_n      = SETTLE_V;
          state_n    = SWEEP_WAIT;
        end
        SWEEP_WAIT, TRK_WAIT: begin
          if (cnt == 8'd0) begin
            mon_req_n   = 1'b1;
            mon_sel_n   = ch;
            req_armed_n = 1'b0;
            state_n     = (state == SWEEP_WAIT) ? SWEEP_SAMP : TRK_SAMP;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        SWEEP_SAMP: begin
          // a strobe in the first request cycle is too early to be trusted
          req_armed_n = 1'b1;
          if (req_armed && mon_valid) begin
            mon_req_n = 1'b0;
            if (mon_power > best) begin
              best_n      = mon_power;
              best_code_n = c;
            end
            if (c == CODE_MAX) begin
              code_n[ch]    = best_code_n;
              ref_pwr_n[ch] = best_n;
              dir_n[ch]     = 1'b0;
              locked_n[ch]  = 1'b1;
              if (ch == LAST_CH) begin
                ch_n    = '0;
                state_n = TRK_SET;
              end else begin
                ch_n        = ch + SEL_W'(1);
                c_n         = '0;
                best_n      = '0;
                best_code_n = '0;
                state_n     = SWEEP_SET;
              end
            end else begin
              c_n     = c + CODE_W'(1);
              state_n = SWEEP_SET;
            end
          end
        end
        TRK_SET: begin
          orig_n     = cur;
          code_n[ch] = trial;
          dir_n[ch]  = dir_eff;
          cnt_n      = SETTLE_V;
          state_n    = TRK_WAIT;
        end
        TRK_SAMP: begin
          req_armed_n = 1'b1;
          if (req_armed && mon_valid) begin
            mon_req_n = 1'b0;
            // ref follows the latest sample either way so a sinking peak is tracked
            ref_pwr_n[ch] = mon_power;
            if (mon_power <= ref_pwr[ch]) begin
              code_n[ch] = orig;
              dir_n[ch]  = ~dir[ch];
            end
            ch_n    = (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
            state_n = TRK_SET;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      c         <= '0;
      best      <= '0;
      best_code <= '0;
      orig      <= '0;
      cnt       <= '0;
      code      <= '0;
      ref_pwr   <= '0;
      dir       <= '0;
      locked    <= '0;
      mon_req   <= 1'b0;
      mon_sel   <= '0;
      req_armed <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      c         <= c_n;
      best      <= best_n;
      best_code <= best_code_n;
      orig      <= orig_n;
      cnt       <= cnt_n;
      code      <= code_n;
      ref_pwr   <= ref_pwr_n;
      dir       <= dir_n;
      locked    <= locked_n;
      mon_req   <= mon_req_n;
      mon_sel   <= mon_sel_n;
      req_armed <= req_armed_n;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    ring_pdm_lane #(.CODE_W(CODE_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .code  (code[i]),
      .pdm   (heater_out[i])
    );
  end

  assign heater_code = code;
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_ring_tuning_controller.sv
// Directed bench for ring_tuning_controller: 2 channels, 4-bit codes, short settle,
// with a ring-power model answering monitor requests.

module tb_ring_tuning_controller;
  localparam int NCH = 2, CW = 4, MW = 10, SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n, enable, mon_req, mon_valid, busy;
  logic [0:0]       mon_sel;
  logic [MW-1:0]    mon_power;
  logic [NCH*CW-1:0] heater_code;
  logic [NCH-1:0]   heater_out, locked;

  int n_chk = 0, n_fail = 0;
  int peak [NCH];
  int visits [NCH];
  int req_cnt [NCH];
  int tim_err = 0, sel_err = 0;
  bit flat = 0, rnd = 0, spur = 0;

  ring_tuning_controller #(
    .NUM_CH(NCH), .CODE_W(CW), .MON_W(MW), .SETTLE_CYC(SETTLE), .STEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mon_req(mon_req), .mon_sel(mon_sel),
    .mon_valid(mon_valid), .mon_power(mon_power), .heater_code(heater_code),
    .heater_out(heater_out), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input int ch);
    return int'(heater_code[ch*CW +: CW]);
  endfunction

  function automatic int model(input int ch, input int code);
    int d, p;
    if (flat) return 50;
    d = code - peak[ch];
    if (d < 0) d = -d;
    p = 100 - 10 * d;
    return (p < 0) ? 0 : p;
  endfunction

  // ring monitor: answers each request after a delay, optionally with stray strobes
  initial begin
    int s, d;
    bit live;
    mon_valid = 1'b0;
    mon_power = '0;
    forever begin
      @(negedge clk);
      if (mon_req) begin
        s = int'(mon_sel);
        d = rnd ? int'($urandom_range(20, 1)) : 1;
        live = 1'b1;
        for (int k = 0; k < d && live; k++) begin
          @(negedge clk);
          if (!mon_req) live = 1'b0;
          else if (int'(mon_sel) != s) sel_err++;
        end
        if (live) begin
          mon_valid = 1'b1;
          mon_power = MW'(model(s, code_of(s)));
          @(negedge clk);
          mon_valid = 1'b0;
          visits[s]++;
        end
      end else if (spur && $urandom_range(2, 0) == 0) begin
        mon_valid = 1'b1;
        mon_power = '1;
        @(negedge clk);
        mon_valid = 1'b0;
      end
    end
  end

  // request counting and settle-time measurement from each channel's last code change
  initial begin
    int since [NCH];
    bit chg [NCH];
    int prev [NCH];
    logic prev_req;
    int s;
    for (int i = 0; i < NCH; i++) begin since[i] = 0; chg[i] = 0; prev[i] = 0; end
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (code_of(i) != prev[i]) begin since[i] = 0; chg[i] = 1; end
        else since[i]++;
        prev[i] = code_of(i);
      end
      if (mon_req === 1'b1 && prev_req !== 1'b1) begin
        s = int'(mon_sel);
        req_cnt[s]++;
        if (chg[s]) begin
          if (since[s] != SETTLE + 1) tim_err++;
          chg[s] = 0;
        end
      end
      prev_req = mon_req;
    end
  end

  task automatic clr_counts();
    for (int i = 0; i < NCH; i++) req_cnt[i] = 0;
    tim_err = 0;
    sel_err = 0;
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int k;
    for (k = 0; k < budget && locked !== 2'b11; k++) @(negedge clk);
    chk(tag, locked === 2'b11, 1);
  endtask

  task automatic count_pdm(input int ch, input int cycles, output int ones);
    ones = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      ones += int'(heater_out[ch]);
    end
  endtask

  initial begin
    int ones, v0, err, k;
    bit saw14;
    rst_n = 1'b1; enable = 1'b0;
    peak[0] = 9; peak[1] = 3;
    for (int i = 0; i < NCH; i++) begin visits[i] = 0; req_cnt[i] = 0; end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_code", heater_code, 0);
    chk("rst_pdm", heater_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_req", mon_req, 0);
    chk("rst_sel", mon_sel, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    count_pdm(0, 32, ones);
    chk("pdm_code0", ones, 0);

    // sweep peak-find
    clr_counts();
    enable = 1'b1;
    @(negedge clk);
    chk("busy_run", busy, 1);
    wait_lock("sweep_lock", 3000);
    chk("sweep_code0", code_of(0), 9);
    chk("sweep_code1", code_of(1), 3);
    chk("sweep_req0", req_cnt[0], 16);
    chk("sweep_req1", req_cnt[1], 16);
    chk("sweep_settle", tim_err, 0);

    // tracking: peak of ch0 drifts to 11
    peak[0] = 11;
    @(negedge clk);
    v0 = visits[0];
    for (k = 0; k < 100 && mon_req !== 1'b1; k++) @(negedge clk);
    chk("trk_first_sel", mon_sel, 0);
    chk("trk_first_trial", code_of(0), 10);
    for (k = 0; k < 2000 && visits[0] < v0 + 4; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("trk_drift", code_of(0), 11);
    chk("trk_ch1_near", (code_of(1) >= 2 && code_of(1) <= 4), 1);
    v0 = visits[0]; err = 0;
    for (k = 0; k < 2000 && visits[0] < v0 + 6; k++) begin
      @(negedge clk);
      if (code_of(0) < 10 || code_of(0) > 12) err++;
    end
    chk("trk_osc", err, 0);

    // saturation at the top code
    peak[0] = 15;
    for (k = 0; k < 4000 && code_of(0) != 15; k++) @(negedge clk);
    chk("sat_reach", code_of(0), 15);
    v0 = visits[0]; err = 0; saw14 = 0;
    for (k = 0; k < 2000 && visits[0] < v0 + 6; k++) begin
      @(negedge clk);
      if (code_of(0) == 14) saw14 = 1;
      else if (code_of(0) != 15) err++;
    end
    chk("sat_range", err, 0);
    chk("sat_flip", saw14, 1);

    // abort from tracking
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_locked", locked, 0);
    chk("abort_req", mon_req, 0);

    // handshake robustness: random latency and stray strobes
    peak[0] = 9; peak[1] = 3; rnd = 1; spur = 1;
    clr_counts();
    enable = 1'b1;
    wait_lock("hs_lock", 20000);
    chk("hs_code0", code_of(0), 9);
    chk("hs_code1", code_of(1), 3);
    chk("hs_sel_stable", sel_err, 0);
    chk("hs_req0", req_cnt[0], 16);
    chk("hs_req1", req_cnt[1], 16);
    chk("hs_settle", tim_err, 0);
    rnd = 0; spur = 0;

    // abort with code 5 held, then check PDM duty
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (k = 0; k < 2000 && !(busy && code_of(0) == 5); k++) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("duty_hold5", code_of(0), 5);
    repeat (3) @(negedge clk);
    count_pdm(0, 16, ones);
    chk("duty5_16", ones, 5);
    count_pdm(0, 32, ones);
    chk("duty5_32", ones, 10);

    // abort mid-sweep at c=6
    enable = 1'b1;
    for (k = 0; k < 2000 && !(busy && code_of(0) == 6); k++) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort6_busy", busy, 0);
    chk("abort6_locked", locked, 0);
    chk("abort6_req", mon_req, 0);
    chk("abort6_code", code_of(0), 6);
    repeat (3) @(negedge clk);
    count_pdm(0, 16, ones);
    chk("abort6_pdm", ones, 6);

    // flat response: ties keep the lowest code
    flat = 1;
    enable = 1'b1;
    wait_lock("tie_lock", 3000);
    chk("tie_code0", code_of(0), 0);
    chk("tie_code1", code_of(1), 0);

    // async reset during TRK_WAIT
    @(negedge clk);
    chk("trkwait_trial", code_of(0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", heater_code, 0);
    chk("arst_pdm", heater_out, 0);
    chk("arst_locked", locked, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req", mon_req, 0);
    chk("arst_sel", mon_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
